// File: rtl/jt7759_romarb.sv
// Two-client round-robin arbiter sharing one ROM byte port, with a one-byte
// tagged cache per client so a repeated address is answered without a fetch.
module jt7759_romarb #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_cs,
    input  logic [AW-1:0] a_addr,
    output logic [7:0]    a_data,
    output logic          a_ok,
    input  logic          b_cs,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_data,
    output logic          b_ok,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [AW-1:0] a_tag, b_tag;
    logic          a_valid, b_valid;
    logic          gnt_b;
    logic          last_b;
    logic          a_hit, b_hit, a_pend, b_pend;

    assign a_hit  = a_valid && (a_addr == a_tag);
    assign b_hit  = b_valid && (b_addr == b_tag);
    assign a_ok   = a_cs && a_hit;
    assign b_ok   = b_cs && b_hit;
    assign a_pend = a_cs && !a_hit;
    assign b_pend = b_cs && !b_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            a_data   <= 8'd0;
            b_data   <= 8'd0;
            a_tag    <= '0;
            b_tag    <= '0;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            gnt_b    <= 1'b0;
            last_b   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // A wins when alone, or on a tie when B was served last
                    if (a_pend && (!b_pend || last_b)) begin
                        gnt_b    <= 1'b0;
                        rom_addr <= a_addr;
                        a_tag    <= a_addr;
                        a_valid  <= 1'b0;
                        rom_cs   <= 1'b1;
                        state    <= ISSUE;
                    end else if (b_pend) begin
                        gnt_b    <= 1'b1;
                        rom_addr <= b_addr;
                        b_tag    <= b_addr;
                        b_valid  <= 1'b0;
                        rom_cs   <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        rom_cs <= 1'b0;
                    end
                end
                // rom_ok may still belong to the previous address here
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (rom_ok) begin
                        if (gnt_b) begin
                            b_data  <= rom_data;
                            b_valid <= 1'b1;
                        end else begin
                            a_data  <= rom_data;
                            a_valid <= 1'b1;
                        end
                        rom_cs <= 1'b0;
                        last_b <= gnt_b;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
